signal_generator: RTL and testbench

- Produces a programmable toggling test signal on a single line for the activity detector on the receiving side.
- Emits continuous square waves or fixed-length bursts. A start/stop handshake controls it, with busy and done status outputs.
- Used for loopback self-test of signal-presence indication and for stimulating external links.
- Idle line level is always 0.

---
 rtl/signal_generator_pkg.sv | 14 +
 rtl/signal_generator_half_period_timer.sv | 41 ++++
 rtl/signal_generator.sv | 117 +++++++++++
 tb/tb_signal_generator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/signal_generator_pkg.sv
// Shared types and defaults for the toggling test-signal generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package signal_generator_pkg;

   localparam int C_GEN_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } gen_state_t;

endpackage

// File: rtl/signal_generator_half_period_timer.sv
// Loadable down-counter producing a one-cycle tick each time it reaches zero, then reloading.
// Latency: first tick load_val+1 enabled edges after load, then every load_val+1 edges.
// Backpressure: none; counts whenever en is high.
module signal_generator_half_period_timer
   import signal_generator_pkg::*;
#(
   parameter int C_WIDTH = C_GEN_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               load,
   input  logic [C_WIDTH-1:0] load_val,
   input  logic               en,
   output logic               tick
);

   localparam logic [C_WIDTH-1:0] ONE = C_WIDTH'(1);

   logic [C_WIDTH-1:0] cnt;
   logic [C_WIDTH-1:0] reload;

   assign tick = en && (cnt == '0);

   // Load captures the reload value; when enabled, count down and wrap back to it at zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt    <= '0;
         reload <= '0;
      end else if (load) begin
         cnt    <= load_val;
         reload <= load_val;
      end else if (en) begin
         if (cnt == '0) begin
            cnt <= reload;
         end else begin
            cnt <= cnt - ONE;
         end
      end
   end

endmodule

// File: rtl/signal_generator.sv
// Programmable square-wave / fixed-length burst generator with start/stop handshake.
// Latency: first toggle hp edges after start acceptance; done on the edge of the final toggle.
// Backpressure: none; start ignored while busy, stop ignored outside RUN.
module signal_generator
   import signal_generator_pkg::*;
#(
   parameter int C_WIDTH = C_GEN_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [C_WIDTH-1:0] cfg_half_period,
   input  logic [C_WIDTH-1:0] cfg_edges,
   input  logic               start,
   input  logic               stop,
   output logic               out,
   output logic               busy,
   output logic               done
);

   localparam logic [C_WIDTH-1:0] ONE = C_WIDTH'(1);
   localparam logic [C_WIDTH-1:0] TWO = C_WIDTH'(2);

   gen_state_t         state;
   logic [C_WIDTH-1:0] edge_cnt;
   logic [C_WIDTH-1:0] edges_lat;
   logic               cont_lat;

   logic [C_WIDTH-1:0] hp_m1;
   logic [C_WIDTH-1:0] edges_eff;
   logic [C_WIDTH-1:0] edge_next;
   logic               start_ok;
   logic               last_toggle;
   logic               tick;

   // Effective configuration: hp of 0 acts as 1, edge count rounded down to even with 1 acting as 2.
   always_comb begin
      hp_m1       = (cfg_half_period == '0) ? '0 : cfg_half_period - ONE;
      edges_eff   = {cfg_edges[C_WIDTH-1:1], 1'b0};
      if (cfg_edges == ONE) begin
         edges_eff = TWO;
      end
      start_ok    = (state == IDLE) && start && !stop;
      edge_next   = edge_cnt + ONE;
      last_toggle = !cont_lat && (edge_next == edges_lat);
   end

   signal_generator_half_period_timer #(
      .C_WIDTH (C_WIDTH)
   ) u_timer (
      .clk      (clk),
      .resetn   (resetn),
      .load     (start_ok),
      .load_val (hp_m1),
      .en       (state != IDLE),
      .tick     (tick)
   );

   // Control FSM with registered out/busy/done; a stop at a toggle instant ends the run on that toggle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         out       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         edge_cnt  <= '0;
         edges_lat <= '0;
         cont_lat  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_ok) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  out       <= 1'b0;
                  edge_cnt  <= '0;
                  edges_lat <= edges_eff;
                  cont_lat  <= (cfg_edges == '0);
               end
            end
            RUN: begin
               if (stop && !out) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (tick) begin
                  edge_cnt <= edge_next;
                  if (last_toggle || stop) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     out   <= 1'b0;
                  end else begin
                     out <= ~out;
                  end
               end else if (stop) begin
                  state <= STOPPING;
               end
            end
            STOPPING: begin
               if (tick) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  out   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               out   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signal_generator.sv
// Directed bench for signal_generator: burst table plus hand-written stop, handshake and reset sequences.
// Latency: expectations are expressed relative to the start-acceptance edge T0.
// Backpressure: n/a.
module tb_signal_generator;

   logic        clk;
   logic        resetn;
   logic [15:0] cfg_half_period;
   logic [15:0] cfg_edges;
   logic        start;
   logic        stop;
   logic        out;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] hp;
      logic [15:0] edges;
      int          exp_hp;
      int          exp_e;
   } vec_t;

   vec_t vecs[7];

   signal_generator #(.C_WIDTH(16)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .cfg_half_period (cfg_half_period),
      .cfg_edges       (cfg_edges),
      .start           (start),
      .stop            (stop),
      .out             (out),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0b expected=%0b", name, got, exp);
      end
   endtask

   task automatic chk3(input string tag, input int k, input logic e_out, input logic e_busy,
                       input logic e_done);
      chk($sformatf("%s k=%0d out", tag, k), out, e_out);
      chk($sformatf("%s k=%0d busy", tag, k), busy, e_busy);
      chk($sformatf("%s k=%0d done", tag, k), done, e_done);
   endtask

   // Drives start for one cycle; returns #1 after the acceptance edge T0.
   task automatic apply_start(input logic [15:0] hp, input logic [15:0] e, input string tag);
      cfg_half_period = hp;
      cfg_edges       = e;
      start           = 1'b1;
      stop            = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk3(tag, 0, 1'b0, 1'b1, 1'b0);
   endtask

   // Checks a burst cycle by cycle from T0+1 through T0+E*hp (+1 unless chaining a new start).
   task automatic run_burst(input int hp, input int e, input bit mutate, input bit chain,
                            input logic [15:0] nhp, input logic [15:0] ne, input string tag);
      int total;
      total = hp * e;
      for (int k = 1; k <= total; k++) begin
         @(posedge clk);
         #1;
         if (k < total) chk3(tag, k, 1'(((k / hp) % 2) == 1), 1'b1, 1'b0);
         else           chk3(tag, k, 1'b0, 1'b0, 1'b1);
         if (mutate && k == 1) begin
            cfg_half_period = 16'd1;
            cfg_edges       = 16'd0;
         end
         start = (mutate && k == 2);
      end
      if (chain) begin
         apply_start(nhp, ne, {tag, " chained"});
      end else begin
         @(posedge clk);
         #1;
         chk3(tag, total + 1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      vecs[0] = '{16'd3, 16'd4, 3, 4};
      vecs[1] = '{16'd0, 16'd1, 1, 2};
      vecs[2] = '{16'd2, 16'd5, 2, 4};
      vecs[3] = '{16'd1, 16'd2, 1, 2};
      vecs[4] = '{16'd5, 16'd6, 5, 6};
      vecs[5] = '{16'd1, 16'd3, 1, 2};
      vecs[6] = '{16'd2, 16'd8, 2, 8};

      resetn          = 1'b0;
      cfg_half_period = 16'd0;
      cfg_edges       = 16'd0;
      start           = 1'b0;
      stop            = 1'b0;

      // Reset then idle for 100 cycles.
      repeat (3) @(posedge clk);
      #1;
      chk3("reset", 0, 1'b0, 1'b0, 1'b0);
      resetn = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         chk3("idle", k, 1'b0, 1'b0, 1'b0);
      end

      // Table of bursts, including degenerate half-period and odd edge counts.
      for (int i = 0; i < 7; i++) begin
         apply_start(vecs[i].hp, vecs[i].edges, $sformatf("vec%0d", i));
         run_burst(vecs[i].exp_hp, vecs[i].exp_e, 1'b0, 1'b0, 16'd0, 16'd0,
                   $sformatf("vec%0d", i));
      end

      // Config change and extra start mid-burst, then a start in the done cycle.
      apply_start(16'd3, 16'd4, "mut");
      run_burst(3, 4, 1'b1, 1'b1, 16'd2, 16'd2, "mut");
      run_burst(2, 2, 1'b0, 1'b0, 16'd0, 16'd0, "b2b");

      // start and stop together in IDLE are dropped.
      cfg_half_period = 16'd2;
      cfg_edges       = 16'd4;
      start           = 1'b1;
      stop            = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         chk3("startstop", k, 1'b0, 1'b0, 1'b0);
      end

      // Continuous hp=4, stop while out=1: fall and done at the next scheduled toggle (T0+8).
      apply_start(16'd4, 16'd0, "stop_hi");
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (k < 4)       chk3("stop_hi", k, 1'b0, 1'b1, 1'b0);
         else if (k < 8)  chk3("stop_hi", k, 1'b1, 1'b1, 1'b0);
         else if (k == 8) chk3("stop_hi", k, 1'b0, 1'b0, 1'b1);
         else             chk3("stop_hi", k, 1'b0, 1'b0, 1'b0);
         stop = (k == 5);
      end

      // Continuous hp=4, stop while out=0: done on the edge sampling stop (T0+10), no toggle at T0+12.
      apply_start(16'd4, 16'd0, "stop_lo");
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         if (k < 4)        chk3("stop_lo", k, 1'b0, 1'b1, 1'b0);
         else if (k < 8)   chk3("stop_lo", k, 1'b1, 1'b1, 1'b0);
         else if (k < 10)  chk3("stop_lo", k, 1'b0, 1'b1, 1'b0);
         else if (k == 10) chk3("stop_lo", k, 1'b0, 1'b0, 1'b1);
         else              chk3("stop_lo", k, 1'b0, 1'b0, 1'b0);
         stop = (k == 9);
      end

      // Reset at T0+5 of an hp=3 burst aborts with no done pulse.
      apply_start(16'd3, 16'd4, "rst_mid");
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         chk3("rst_mid", k, 1'(k >= 3), 1'b1, 1'b0);
      end
      @(posedge clk);
      resetn = 1'b0;
      #1;
      chk3("rst_mid abort", 5, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         chk3("rst_after", k, 1'b0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
